// File: rtl/rbzero_reg_loader.sv
// Host-side register-write queue that replays each write as one SPI mode-0 frame on rbzero's reg SPI pins.
// Optional: define RBZERO_REG_LOADER_VBLANK_GATE_EN to start frames only while i_vblank is high.
module rbzero_reg_loader #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 24,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr_valid,
  input  logic [ADDR_W-1:0]          i_wr_addr,
  input  logic [DATA_W-1:0]          i_wr_data,
  output logic                       o_wr_ready,
  input  logic                       i_flush,
  input  logic                       i_vblank,
  output logic                       o_reg_sclk,
  output logic                       o_reg_mosi,
  output logic                       o_reg_ss_n,
  output logic                       o_busy,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int N     = ADDR_W + DATA_W;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int BIT_W = $clog2(N);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_HIGH, S_LOW, S_TAIL, S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [N-2:0]      sh_q, sh_d;
  logic              sclk_q, sclk_d, mosi_q, mosi_d, ss_n_q, ss_n_d;
  logic              full, push, pop, start_ok, phase_done, last_bit;

`ifdef RBZERO_REG_LOADER_VBLANK_GATE_EN
  assign start_ok = i_vblank;
`else
  logic unused_vblank;
  assign unused_vblank = i_vblank;
  assign start_ok      = 1'b1;
`endif

  // Write handshake: an entry is accepted on an edge where i_wr_valid and o_wr_ready are both high
  // and i_flush is low; o_wr_ready depends only on occupancy, never on i_wr_valid.
  assign full       = (level_q == LVL_W'(DEPTH));
  assign o_wr_ready = !full;
  assign push       = i_wr_valid && !full && !i_flush;
  assign pop        = (state_q == S_IDLE) && (level_q != '0) && start_ok;
  assign phase_done = (div_q == DIV_W'(CLK_DIV - 1));
  assign last_bit   = (bit_q == BIT_W'(N - 1));

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_wr_addr, i_wr_data};
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (i_flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (pop && !push) begin
      level_d = level_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ss_n_d  = ss_n_q;
    if (state_q != S_IDLE) div_d = phase_done ? '0 : div_q + 1'b1;
    case (state_q)
      S_IDLE: if (pop) begin
        // The frame MSB goes straight to mosi; the shifter only holds the remaining bits.
        mosi_d  = mem_q[rd_ptr_q][N-1];
        sh_d    = mem_q[rd_ptr_q][N-2:0];
        bit_d   = '0;
        div_d   = '0;
        ss_n_d  = 1'b0;
        sclk_d  = 1'b0;
        state_d = S_LEAD;
      end
      S_LEAD: if (phase_done) begin
        sclk_d  = 1'b1;
        state_d = S_HIGH;
      end
      S_HIGH: if (phase_done) begin
        sclk_d = 1'b0;
        if (last_bit) begin
          state_d = S_TAIL;
        end else begin
          mosi_d  = sh_q[N-2];
          sh_d    = sh_q << 1;
          bit_d   = bit_q + 1'b1;
          state_d = S_LOW;
        end
      end
      S_LOW: if (phase_done) begin
        sclk_d  = 1'b1;
        state_d = S_HIGH;
      end
      S_TAIL: if (phase_done) begin
        ss_n_d  = 1'b1;
        mosi_d  = 1'b0;
        state_d = S_GAP;
      end
      S_GAP: if (phase_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      ss_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      ss_n_q   <= ss_n_d;
    end
  end

  assign o_reg_sclk = sclk_q;
  assign o_reg_mosi = mosi_q;
  assign o_reg_ss_n = ss_n_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_level    = level_q;

endmodule

// File: tb/tb_rbzero_reg_loader.sv
// Directed bench for rbzero_reg_loader: default instance (28-bit frames, CLK_DIV=2) plus a
// CLK_DIV=1 / DATA_W=8 instance; SPI monitors decode frames into a shared scoreboard.
module tb_rbzero_reg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        vblank;
  logic        a_wr_valid, a_wr_ready, a_flush, a_sclk, a_mosi, a_ss_n, a_busy;
  logic [3:0]  a_wr_addr;
  logic [23:0] a_wr_data;
  logic [2:0]  a_level;
  logic        b_wr_valid, b_wr_ready, b_flush, b_sclk, b_mosi, b_ss_n, b_busy;
  logic [3:0]  b_wr_addr;
  logic [7:0]  b_wr_data;
  logic [2:0]  b_level;

  rbzero_reg_loader u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_wr_valid(a_wr_valid), .i_wr_addr(a_wr_addr),
    .i_wr_data(a_wr_data), .o_wr_ready(a_wr_ready), .i_flush(a_flush), .i_vblank(vblank),
    .o_reg_sclk(a_sclk), .o_reg_mosi(a_mosi), .o_reg_ss_n(a_ss_n), .o_busy(a_busy),
    .o_level(a_level)
  );

  rbzero_reg_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(4), .CLK_DIV(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_wr_valid(b_wr_valid), .i_wr_addr(b_wr_addr),
    .i_wr_data(b_wr_data), .o_wr_ready(b_wr_ready), .i_flush(b_flush), .i_vblank(vblank),
    .o_reg_sclk(b_sclk), .o_reg_mosi(b_mosi), .o_reg_ss_n(b_ss_n), .o_busy(b_busy),
    .o_level(b_level)
  );

  // Scoreboard
  logic [27:0] exp_q[$];
  logic [27:0] got_q[$];
  int          len_q[$];
  int          bits_q[$];
  int          gap_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor for instance A: bits are taken on sclk rising edges while ss_n is low
  logic [27:0] a_sh;
  int          a_bits = 0, a_len = 0, a_gap = 0;
  bit          a_in = 0, a_prev_sclk = 0, a_have_prev = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      a_in = 0; a_bits = 0; a_prev_sclk = 0; a_have_prev = 0;
    end else begin
      if (!a_ss_n) begin
        if (!a_in) begin
          if (a_have_prev) gap_q.push_back(a_gap);
          a_in = 1; a_bits = 0; a_len = 0; a_sh = '0;
        end
        a_len++;
        if (a_sclk && !a_prev_sclk) begin
          a_sh = {a_sh[26:0], a_mosi};
          a_bits++;
        end
      end else if (a_in) begin
        got_q.push_back(a_sh); len_q.push_back(a_len); bits_q.push_back(a_bits);
        a_in = 0; a_gap = 1; a_have_prev = 1;
      end else begin
        a_gap++;
      end
      a_prev_sclk = a_sclk;
    end
  end

  // Monitor for instance B, also timing sclk rising-edge spacing
  logic [11:0] b_sh;
  int          b_bits = 0, b_len = 0, b_cyc = 0, b_last_rise = -1, b_period = 0;
  bit          b_in = 0, b_prev_sclk = 0;
  always @(negedge clk) begin
    b_cyc++;
    if (!rst_n) begin
      b_in = 0; b_bits = 0; b_prev_sclk = 0;
    end else begin
      if (!b_ss_n) begin
        if (!b_in) begin
          b_in = 1; b_bits = 0; b_len = 0; b_sh = '0; b_last_rise = -1;
        end
        b_len++;
        if (b_sclk && !b_prev_sclk) begin
          b_sh = {b_sh[10:0], b_mosi};
          b_bits++;
          if (b_last_rise >= 0) b_period = b_cyc - b_last_rise;
          b_last_rise = b_cyc;
        end
      end else if (b_in) begin
        got_q.push_back(28'(b_sh)); len_q.push_back(b_len); bits_q.push_back(b_bits);
        b_in = 0;
      end
      b_prev_sclk = b_sclk;
    end
  end

  logic [27:0] vec [8] = '{28'h1123456, 28'h2ABCDEF, 28'h3000001, 28'hC800000,
                           28'hF0F0F0F, 28'h7777777, 28'h5A5C3F0, 28'h9E1D2C3};

  task automatic burst_a(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      a_wr_valid = 1'b1;
      {a_wr_addr, a_wr_data} = vec[first + i];
    end
    @(posedge clk); #1;
    a_wr_valid = 1'b0;
  endtask

  task automatic wait_quiet(input bit sel, input string tag);
    int idle_run;
    idle_run = 0;
    for (int i = 0; i < 3000 && idle_run < 4; i++) begin
      @(negedge clk);
      if (!(sel ? b_busy : a_busy)) idle_run++;
      else idle_run = 0;
    end
    check(tag, sel ? b_busy : a_busy, 0);
  endtask

  task automatic compare_frames(input int exp_len, input int exp_bits);
    check("frame_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check("frame_bits_value", got_q.pop_front(), exp_q.pop_front());
      check("frame_ss_n_low_cycles", len_q.pop_front(), exp_len);
      check("frame_sclk_rises", bits_q.pop_front(), exp_bits);
    end
    exp_q.delete(); got_q.delete(); len_q.delete(); bits_q.delete(); gap_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    a_wr_valid = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_flush = 1'b0;
    b_wr_valid = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_flush = 1'b0;
`ifdef RBZERO_REG_LOADER_VBLANK_GATE_EN
    vblank = 1'b1;
`else
    vblank = 1'b0;
`endif

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ss_n", a_ss_n, 1);
    check("rst_sclk", a_sclk, 0);
    check("rst_mosi", a_mosi, 0);
    check("rst_busy", a_busy, 0);
    check("rst_level", a_level, 0);
    check("rst_wr_ready", a_wr_ready, 1);
    check("rst_b_ss_n", b_ss_n, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single write: ss_n falls the edge after the push
    burst_a(6, 1);
    @(negedge clk);
    check("t1_level_after_push", a_level, 1);
    check("t1_ss_n_before_start", a_ss_n, 1);
    @(negedge clk);
    check("t1_ss_n_start", a_ss_n, 0);
    check("t1_busy_start", a_busy, 1);
    check("t1_level_popped", a_level, 0);
    check("t1_first_mosi", a_mosi, 0);
    exp_q.push_back(28'h5A5C3F0);
    wait_quiet(0, "t1_idle");
    compare_frames(114, 28);

    // Six back-to-back pushes: the sixth hits a full FIFO and is dropped
    burst_a(0, 6);
    @(negedge clk);
    check("t2_level_full", a_level, 4);
    check("t2_wr_ready_full", a_wr_ready, 0);
    for (int i = 0; i < 5; i++) exp_q.push_back(vec[i]);
    wait_quiet(0, "t2_idle");
    check("t2_level_drained", a_level, 0);
    foreach (gap_q[i]) check("t2_gap_ge_3", gap_q[i] >= 3, 1);
    compare_frames(114, 28);

    // Flush during frame 1: frame 1 completes, queued entries vanish
    burst_a(0, 3);
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t3_level_pre_flush", a_level, 2);
    @(posedge clk); #1;
    a_flush = 1'b1;
    @(posedge clk); #1;
    a_flush = 1'b0;
    @(negedge clk);
    check("t3_level_flushed", a_level, 0);
    check("t3_busy_in_flight", a_busy, 1);
    exp_q.push_back(vec[0]);
    wait_quiet(0, "t3_idle");
    repeat (40) @(posedge clk);
    compare_frames(114, 28);

    // Reset around bit 10: frame aborts, nothing resumes
    burst_a(3, 2);
    for (int i = 0; i < 400 && a_bits < 10; i++) @(negedge clk);
    check("t4_mid_frame", a_ss_n, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t4_rst_ss_n", a_ss_n, 1);
    check("t4_rst_sclk", a_sclk, 0);
    check("t4_rst_mosi", a_mosi, 0);
    check("t4_rst_level", a_level, 0);
    check("t4_rst_busy", a_busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    check("t4_no_resume_ss_n", a_ss_n, 1);
    compare_frames(114, 28);

    // Fast instance: CLK_DIV=1, 12-bit frame
    @(posedge clk); #1;
    b_wr_valid = 1'b1; b_wr_addr = 4'hF; b_wr_data = 8'h81;
    @(posedge clk); #1;
    b_wr_valid = 1'b0;
    exp_q.push_back(28'hF81);
    wait_quiet(1, "t5_idle");
    check("t5_sclk_period", b_period, 2);
    compare_frames(25, 12);

`ifdef RBZERO_REG_LOADER_VBLANK_GATE_EN
    // Frames wait for vblank; a frame in progress survives vblank falling
    vblank = 1'b0;
    burst_a(1, 2);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("t6_gated_ss_n", a_ss_n, 1);
    check("t6_gated_level", a_level, 2);
    @(posedge clk); #1;
    vblank = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    vblank = 1'b0;
    @(negedge clk);
    check("t6_frame1_running", a_busy, 1);
    wait_quiet(0, "t6_frame1_done");
    repeat (50) @(posedge clk);
    @(negedge clk);
    check("t6_frame2_waits_level", a_level, 1);
    check("t6_frame2_waits_ss_n", a_ss_n, 1);
    exp_q.push_back(vec[1]);
    compare_frames(114, 28);
    @(posedge clk); #1;
    vblank = 1'b1;
    exp_q.push_back(vec[2]);
    wait_quiet(0, "t6_frame2_done");
    compare_frames(114, 28);
`else
    // vblank low has no effect on frame start
    vblank = 1'b0;
    burst_a(7, 1);
    @(negedge clk);
    @(negedge clk);
    check("t6_ungated_start", a_ss_n, 0);
    exp_q.push_back(vec[7]);
    wait_quiet(0, "t6_idle");
    compare_frames(114, 28);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/rbzero_reg_loader.md
Name: rbzero_reg_loader

Overview:
- Queues register writes (address + data) from a host-side parallel interface.
- Serialises each write as one SPI-mode-0 frame onto rbzero's alt register SPI inputs (i_reg_sclk, i_reg_mosi, i_reg_ss_n).
- Lets on-chip logic or a test harness configure rbzero without an external SPI master.
- Sits beside rbzero in the top level and drives its reg SPI pins.

Parameters:
- ADDR_W, 4, register address bits; sent first, MSB first.
- DATA_W, 24, data bits; sent after the address, MSB first.
- DEPTH, 4, FIFO entries (power of 2, >=2).
- CLK_DIV, 2, clk cycles per SPI half-period (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- i_wr_valid  in  1  host write request
- i_wr_addr  in  ADDR_W  register address
- i_wr_data  in  DATA_W  register data
- o_wr_ready  out  1  FIFO can accept an entry
- i_flush  in  1  discard queued (not in-flight) entries
- i_vblank  in  1  rbzero o_vblank, used only by optional gating
- o_reg_sclk  out  1  SPI clock to rbzero i_reg_sclk
- o_reg_mosi  out  1  SPI data to rbzero i_reg_mosi
- o_reg_ss_n  out  1  SPI select to rbzero i_reg_ss_n
- o_busy  out  1  frame in progress (state != IDLE)
- o_level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-low (rst_n sampled on posedge clk).
- Reset values: o_reg_ss_n=1, o_reg_sclk=0, o_reg_mosi=0, o_busy=0, o_level=0, o_wr_ready=1, FIFO empty, state IDLE.
- Reset mid-frame aborts the frame; outputs take reset values on the next edge.
- All SPI outputs are registered.
- FIFO push: an entry is written when i_wr_valid && o_wr_ready. o_wr_ready = (level != DEPTH).
- FIFO full: no bypass. A push while full is ignored, even if a pop happens in the same cycle.
- Push and pop in the same cycle (not full): level is unchanged.
- Pointers wrap modulo DEPTH.
- i_flush: on the next edge, level=0 and pointers are equalised. An in-flight frame completes.
- i_flush and push in the same cycle: flush wins, the push is dropped.
- Frame length N = ADDR_W+DATA_W bits. A per-phase counter counts CLK_DIV cycles; a bit counter counts 0..N-1.
- IDLE: if level>0 (and gate allows), pop the head into the shift register. Set ss_n=0, sclk=0, mosi=addr MSB. Go to LEAD.
- LEAD: after CLK_DIV cycles, set sclk=1 and go to HIGH. rbzero samples on this rising edge.
- HIGH: after CLK_DIV cycles, set sclk=0.
  - Last bit: go to TAIL.
  - Otherwise: shift, mosi=next bit, go to LOW.
- LOW: after CLK_DIV cycles, set sclk=1 and go to HIGH.
- TAIL: after CLK_DIV cycles, set ss_n=1, mosi=0. Go to GAP.
- GAP: after CLK_DIV cycles, go to IDLE. This guarantees a deselect time of >= CLK_DIV cycles.
- Frame duration from ss_n falling to ss_n rising is (2N+1)*CLK_DIV cycles. Next ss_n fall occurs >= CLK_DIV+1 cycles after ss_n rises.
- mosi changes only while sclk is low, or at the ss_n falling edge.
- o_busy=1 in every state except IDLE.
- Entries are transmitted strictly in FIFO order. No entry is lost except by flush or reset.

Optional Feature:
- Macro: RBZERO_REG_LOADER_VBLANK_GATE_EN.
- Defined: IDLE starts a frame only when level>0 && i_vblank==1. i_vblank falling mid-frame does not abort; the frame finishes and the next one waits for the next i_vblank high.
- Undefined: i_vblank is ignored (tied into an unused-signal sink) and frames start whenever level>0.

Test Plan:
- Reset with defaults, one push addr=4'h5 data=24'hA5C3F0 -> ss_n falls one cycle after push. The 28 bits sampled on sclk rising edges are 0101_1010_0101_1100_0011_1111_0000. ss_n low for 57*2=114 cycles, then high.
- Push 5 entries back-to-back while idle -> the first is popped immediately, entries 2-5 fill the FIFO (level=4, o_wr_ready=0 reached). A 6th push while full is dropped. Frames appear in order with ss_n high >= 3 cycles between them.
- Queue 3 entries, assert i_flush during frame 1 -> frame 1 completes intact, level=0, no further frames; o_busy falls after GAP.
- Assert rst_n=0 at bit 10 of a frame -> next edge: ss_n=1, sclk=0, mosi=0, level=0. After release, no partial frame resumes.
- CLK_DIV=1, DATA_W=8, push addr=4'hF data=8'h81 -> sclk period 2 cycles, frame 25 cycles, bits 1111_1000_0001.
- With RBZERO_REG_LOADER_VBLANK_GATE_EN: i_vblank=0, push 2 entries -> ss_n stays 1. Raise i_vblank for 10 cycles -> frame 1 starts and completes after i_vblank drops; frame 2 waits for the next i_vblank rise.
